// File: rtl/led_pwm_pkg.sv
// led_pwm_pkg: shared constants for the memory-mapped PWM LED peripheral.
// Holds the register offsets, the CTRL bit positions and the window size.
package led_pwm_pkg;

   // Size of the register window in bytes.
   localparam int WINDOW_SIZE = 16;

   // Register offsets inside the window.
   localparam logic [3:0] REG_CTRL     = 4'd0;
   localparam logic [3:0] REG_PRESCALE = 4'd1;
   localparam logic [3:0] REG_DUTY0    = 4'd2;

   // CTRL bit positions.
   localparam int CTRL_EN        = 0;
   localparam int CTRL_INV       = 1;
   localparam int CTRL_FADE_DONE = 2;

   // Offset of the DUTY register for a given channel.
   function automatic logic [3:0] duty_offset(input int ch);
      return 4'(int'(REG_DUTY0) + ch);
   endfunction

endpackage

// File: rtl/led_pwm_channel.sv
// led_pwm_channel: one LED channel. Keeps the duty shadow that is only
// updated at period starts, optionally fades it one step per period, and
// produces the registered compare/invert LED drive.
// Optional build macro: LED_PWM_FADE_EN (shadow steps toward the target).
module led_pwm_channel #(
   parameter int DUTY_W = 8
) (
   input  logic              clk,
   input  logic              srst,
   input  logic [DUTY_W-1:0] duty,
   input  logic [DUTY_W-1:0] pwm_cnt,
   input  logic              period_start,
   input  logic              en,
   input  logic              inv,
   output logic              led,
   output logic              done
);

   logic [DUTY_W-1:0] shadow_reg;
   logic              led_reg;

`ifdef LED_PWM_FADE_EN
   logic en_d_reg;

   // Remember EN so the enable-edge load restarts the fade from zero.
   always_ff @(posedge clk) begin
      if (srst) en_d_reg <= 1'b0;
      else      en_d_reg <= en;
   end

   // At each period start move the shadow one step toward the target.
   always_ff @(posedge clk) begin
      if (srst) begin
         shadow_reg <= '0;
      end else if (period_start) begin
         if (en && !en_d_reg)        shadow_reg <= '0;
         else if (shadow_reg < duty) shadow_reg <= shadow_reg + 1'b1;
         else if (shadow_reg > duty) shadow_reg <= shadow_reg - 1'b1;
      end
   end

   assign done = (shadow_reg == duty);
`else
   // Shadow takes the target duty only at period starts (glitch-free update).
   always_ff @(posedge clk) begin
      if (srst)              shadow_reg <= '0;
      else if (period_start) shadow_reg <= duty;
   end

   assign done = 1'b0;
`endif

   // Registered LED drive: compare against the shadow, then apply polarity.
   always_ff @(posedge clk) begin
      if (srst)    led_reg <= 1'b0;
      else if (en) led_reg <= (pwm_cnt < shadow_reg) ^ inv;
      else         led_reg <= inv;
   end

   assign led = led_reg;

endmodule

// File: rtl/led_pwm_port.sv
// led_pwm_port: multi-channel PWM LED peripheral on the 6502 bus.
// Decodes a 16-byte window, holds CTRL/PRESCALE/DUTY registers, runs the
// prescaler and PWM counter, and feeds one led_pwm_channel per LED.
// Read data is registered (one-cycle latency, like synchronous RAM).
// Optional build macro: LED_PWM_FADE_EN (handled in led_pwm_channel).
module led_pwm_port #(
   parameter int          NUM_CH     = 4,
   parameter logic [15:0] BASE_ADDR  = 16'hD000,
   parameter int          DUTY_W     = 8,
   parameter int          PRESCALE_W = 8
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic [15:0]       ab,
   input  logic [7:0]        db_in,
   input  logic              we,
   output logic [7:0]        rd_data,
   output logic              rd_hit,
   output logic [NUM_CH-1:0] leds
);

   import led_pwm_pkg::*;

   localparam int OFF_W = $clog2(WINDOW_SIZE);

   logic                  hit;
   logic [OFF_W-1:0]      off;
   logic                  wr;

   logic                  ctrl_en_reg;
   logic                  ctrl_inv_reg;
   logic [PRESCALE_W-1:0] prescale_reg;
   logic [DUTY_W-1:0]     duty_reg [NUM_CH];

   logic [PRESCALE_W-1:0] pre_cnt_reg;
   logic [DUTY_W-1:0]     pwm_cnt_reg;
   logic                  en_d_reg;
   logic                  tick;
   logic                  period_start;

   logic [NUM_CH-1:0]     done_vec;
   logic [7:0]            rd_next;
   logic [7:0]            rd_data_reg;
   logic                  rd_hit_reg;

   assign hit = (ab[15:OFF_W] == BASE_ADDR[15:OFF_W]);
   assign off = ab[OFF_W-1:0];
   assign wr  = hit && we;

   // Register file: the addressed register takes the bus data on a write hit.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         ctrl_en_reg  <= 1'b0;
         ctrl_inv_reg <= 1'b0;
         prescale_reg <= '0;
         for (int i = 0; i < NUM_CH; i++) duty_reg[i] <= '0;
      end else if (wr) begin
         if (off == REG_CTRL) begin
            ctrl_en_reg  <= db_in[CTRL_EN];
            ctrl_inv_reg <= db_in[CTRL_INV];
         end
         if (off == REG_PRESCALE) prescale_reg <= PRESCALE_W'(db_in);
         for (int i = 0; i < NUM_CH; i++) begin
            if (off == duty_offset(i)) duty_reg[i] <= DUTY_W'(db_in);
         end
      end
   end

   // >= rather than == so a smaller PRESCALE written mid-count acts at once.
   assign tick = ctrl_en_reg && (pre_cnt_reg >= prescale_reg);

   // Prescaler and PWM counter; both held at zero while disabled.
   always_ff @(posedge sys_clk) begin
      if (reset || !ctrl_en_reg) begin
         pre_cnt_reg <= '0;
         pwm_cnt_reg <= '0;
      end else begin
         pre_cnt_reg <= tick ? '0 : pre_cnt_reg + 1'b1;
         if (tick) pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
      end
   end

   // Delayed EN, used to spot the first enabled cycle.
   always_ff @(posedge sys_clk) begin
      if (reset) en_d_reg <= 1'b0;
      else       en_d_reg <= ctrl_en_reg;
   end

   // Shadows load when the counter wraps to 0, and on the first enabled cycle.
   assign period_start = (tick && (pwm_cnt_reg == '1)) ||
                         (ctrl_en_reg && !en_d_reg);

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         led_pwm_channel #(
            .DUTY_W (DUTY_W)
         ) u_ch (
            .clk          (sys_clk),
            .srst         (reset),
            .duty         (duty_reg[gi]),
            .pwm_cnt      (pwm_cnt_reg),
            .period_start (period_start),
            .en           (ctrl_en_reg),
            .inv          (ctrl_inv_reg),
            .led          (leds[gi]),
            .done         (done_vec[gi])
         );
      end
   endgenerate

   // Read mux from the current address; unmapped offsets read zero.
   always_comb begin
      rd_next = '0;
      if (hit) begin
         if (off == REG_CTRL) begin
            rd_next[CTRL_EN]        = ctrl_en_reg;
            rd_next[CTRL_INV]       = ctrl_inv_reg;
            rd_next[CTRL_FADE_DONE] = &done_vec;
         end else if (off == REG_PRESCALE) begin
            rd_next = 8'(prescale_reg);
         end else begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (off == duty_offset(i)) rd_next = 8'(duty_reg[i]);
            end
         end
      end
   end

   // Registered read port; a same-cycle write still returns the old value.
   always_ff @(posedge sys_clk) begin
      if (reset) begin
         rd_data_reg <= '0;
         rd_hit_reg  <= 1'b0;
      end else begin
         rd_data_reg <= rd_next;
         rd_hit_reg  <= hit && !we;
      end
   end

   assign rd_data = rd_data_reg;
   assign rd_hit  = rd_hit_reg;

endmodule

// File: tb/tb_led_pwm_port.sv
// tb_led_pwm_port: directed bench for led_pwm_port.
// Covers reset, bus read/write, duty ratios, glitch-free updates, prescale,
// inversion and reset mid-period. With LED_PWM_FADE_EN defined the duty-ratio
// tests are replaced by a fade test.
module tb_led_pwm_port;

   logic        sys_clk = 1'b0;
   logic        reset;
   logic [15:0] ab;
   logic [7:0]  db_in;
   logic        we;
   logic [7:0]  rd_data;
   logic        rd_hit;
   logic [3:0]  leds;

   int checks = 0;
   int errors = 0;

   led_pwm_port #(
      .NUM_CH     (4),
      .BASE_ADDR  (16'hD000),
      .DUTY_W     (8),
      .PRESCALE_W (8)
   ) dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .ab      (ab),
      .db_in   (db_in),
      .we      (we),
      .rd_data (rd_data),
      .rd_hit  (rd_hit),
      .leds    (leds)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end else begin
         $display("ok   %s got=%0h", tag, got);
      end
   endtask

   // Write cycle; returns on the falling edge right after the write edge.
   task automatic bus_write(input logic [15:0] addr, input logic [7:0] data);
      @(negedge sys_clk);
      ab = addr; db_in = data; we = 1'b1;
      @(negedge sys_clk);
      we = 1'b0; ab = 16'h0000; db_in = 8'h00;
   endtask

   // Read cycle; samples the registered response one clock later.
   task automatic bus_read(input logic [15:0] addr, output logic [7:0] data, output logic hitv);
      @(negedge sys_clk);
      ab = addr; we = 1'b0;
      @(negedge sys_clk);
      data = rd_data; hitv = rd_hit;
      ab = 16'h0000;
   endtask

   logic [7:0] rdv;
   logic       hv;
   int         cnt [4];
   int         cnt_b;
   logic [7:0] exp_rb [6];

   initial begin
      reset = 1'b1; ab = 16'h0000; db_in = 8'h00; we = 1'b0;

      // ---- reset ----
      repeat (3) @(posedge sys_clk);
      @(negedge sys_clk);
      reset = 1'b0;
      check_eq("rst_leds", 32'(leds), 32'h0);
      check_eq("rst_rd_hit", 32'(rd_hit), 32'h0);
      check_eq("rst_rd_data", 32'(rd_data), 32'h0);
      for (int a = 0; a < 6; a++) begin
         bus_read(16'hD000 + 16'(a), rdv, hv);
         check_eq($sformatf("rst_reg%0d", a), 32'(rdv), 32'h0);
      end

      // ---- bus readback ----
      bus_write(16'hD000, 8'h02);
      bus_write(16'hD001, 8'h03);
      bus_write(16'hD002, 8'h5A);
      bus_write(16'hD004, 8'hFF);
      bus_write(16'hD005, 8'h40);
      bus_read(16'hD002, rdv, hv);
      check_eq("rb_d002_hit", 32'(hv), 32'h1);
      check_eq("rb_d002_data", 32'(rdv), 32'h5A);
      bus_read(16'hD00F, rdv, hv);
      check_eq("rb_d00f_data", 32'(rdv), 32'h0);
      check_eq("rb_d00f_hit", 32'(hv), 32'h1);
      bus_read(16'hC002, rdv, hv);
      check_eq("rb_c002_hit", 32'(hv), 32'h0);
      check_eq("rb_c002_data", 32'(rdv), 32'h0);
      // CTRL=0x02: disabled with INV set, so every LED sits at 1.
      check_eq("rb_inv_idle_leds", 32'(leds), 32'hF);
      bus_write(16'hD00F, 8'hFF);
      exp_rb = '{8'h02, 8'h03, 8'h5A, 8'h00, 8'hFF, 8'h40};
      for (int a = 0; a < 6; a++) begin
         bus_read(16'hD000 + 16'(a), rdv, hv);
         check_eq($sformatf("rb_after_d00f_reg%0d", a), 32'(rdv), 32'(exp_rb[a]));
      end
      // Same-cycle write returns the old value and does not flag a hit.
      @(negedge sys_clk);
      ab = 16'hD001; db_in = 8'h07; we = 1'b1;
      @(negedge sys_clk);
      check_eq("rb_wr_old_data", 32'(rd_data), 32'h03);
      check_eq("rb_wr_hit", 32'(rd_hit), 32'h0);
      we = 1'b0; ab = 16'h0000;
      bus_read(16'hD001, rdv, hv);
      check_eq("rb_wr_new_data", 32'(rdv), 32'h07);

`ifndef LED_PWM_FADE_EN
      // ---- duty ratios, PRESCALE=0 ----
      bus_write(16'hD000, 8'h00);
      bus_write(16'hD001, 8'h00);
      bus_write(16'hD002, 8'h80);
      bus_write(16'hD003, 8'h00);
      bus_write(16'hD004, 8'hFF);
      bus_write(16'hD005, 8'h40);
      bus_write(16'hD000, 8'h01);
      for (int c = 0; c < 4; c++) cnt[c] = 0;
      // Sample k reflects counter value k-1 (mod 256); period 1 is k=257..512.
      for (int k = 1; k <= 512; k++) begin
         @(negedge sys_clk);
         if (k >= 257) for (int c = 0; c < 4; c++) if (leds[c]) cnt[c]++;
      end
      check_eq("duty_led0_80", 32'(cnt[0]), 32'd128);
      check_eq("duty_led1_00", 32'(cnt[1]), 32'd0);
      check_eq("duty_led2_ff", 32'(cnt[2]), 32'd255);
      check_eq("duty_led3_40", 32'(cnt[3]), 32'd64);
      bus_read(16'hD000, rdv, hv);
      check_eq("duty_ctrl_read", 32'(rdv), 32'h01);

      // ---- glitch-free update: DUTY0 0x80 -> 0x20 at counter 0x10 ----
      bus_write(16'hD000, 8'h00);
      bus_write(16'hD000, 8'h01);
      cnt[0] = 0; cnt_b = 0;
      for (int k = 1; k <= 768; k++) begin
         @(negedge sys_clk);
         if (k >= 257 && k <= 512 && leds[0]) cnt[0]++;
         if (k >= 513 && leds[0]) cnt_b++;
         if (k == 272) begin
            ab = 16'hD002; db_in = 8'h20; we = 1'b1;
         end
         if (k == 273) begin
            we = 1'b0; ab = 16'h0000; db_in = 8'h00;
         end
      end
      check_eq("glitch_cur_period", 32'(cnt[0]), 32'd128);
      check_eq("glitch_next_period", 32'(cnt_b), 32'd32);

      // ---- prescale 3 with invert ----
      bus_write(16'hD000, 8'h00);
      bus_write(16'hD001, 8'h03);
      bus_write(16'hD002, 8'h80);
      bus_write(16'hD000, 8'h03);
      cnt[0] = 0; cnt[1] = 0;
      for (int k = 1; k <= 2048; k++) begin
         @(negedge sys_clk);
         if (k >= 1025) begin
            if (!leds[0]) cnt[0]++;
            if (!leds[1]) cnt[1]++;
         end
      end
      check_eq("pre3_led0_low", 32'(cnt[0]), 32'd512);
      check_eq("pre3_led1_low", 32'(cnt[1]), 32'd0);
      bus_write(16'hD000, 8'h02);
      @(negedge sys_clk);
      check_eq("disable_inv_leds", 32'(leds), 32'hF);
      bus_read(16'hD001, rdv, hv);
      check_eq("disable_keeps_prescale", 32'(rdv), 32'h03);
`else
      // ---- fade: shadow climbs 0..4 over the first periods ----
      bus_write(16'hD000, 8'h00);
      bus_write(16'hD001, 8'h00);
      bus_write(16'hD002, 8'h04);
      bus_write(16'hD003, 8'h00);
      bus_write(16'hD004, 8'h00);
      bus_write(16'hD005, 8'h00);
      bus_write(16'hD000, 8'h01);
      repeat (600) @(negedge sys_clk);
      bus_read(16'hD000, rdv, hv);
      check_eq("fade_not_done", 32'(rdv), 32'h01);
      repeat (1200) @(negedge sys_clk);
      bus_read(16'hD000, rdv, hv);
      check_eq("fade_done", 32'(rdv), 32'h05);
`endif

      // ---- reset mid-period ----
      bus_write(16'hD001, 8'h00);
      bus_write(16'hD004, 8'hFF);
      bus_write(16'hD000, 8'h01);
      repeat (50) @(negedge sys_clk);
      reset = 1'b1;
      @(negedge sys_clk);
      reset = 1'b0;
      check_eq("midrst_leds", 32'(leds), 32'h0);
      bus_read(16'hD000, rdv, hv);
      check_eq("midrst_ctrl", 32'(rdv), 32'h0);
      bus_read(16'hD004, rdv, hv);
      check_eq("midrst_duty2", 32'(rdv), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
